// File: rtl/m_latency_memory_pkg.sv
// Shared types and constants for the latency memory model.
package m_latency_memory_pkg;

  // Width of the access-latency down-counter.
  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StReadWait  = 2'd1,
    StWriteWait = 2'd2
  } lmem_state_e;

  // Saturating increment for the 32-bit statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/m_lmem_array.sv
// Word array with asynchronous read and byte-enable synchronous write.
// The init port owns the write path while init_done is low; afterwards the core port does.
module m_lmem_array
  import m_latency_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned BE        = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  init_done,
  input  logic [BE-1:0]         init_wen,
  input  logic [ADDR_WIDTH-1:0] init_addr,
  input  logic [DATA_WIDTH-1:0] init_data,
  input  logic [BE-1:0]         core_wen,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [BE-1:0]         wen_sel;
  logic [ADDR_WIDTH-1:0] waddr_sel;
  logic [DATA_WIDTH-1:0] wdata_sel;

  // Select the write source: init port during preload, core port afterwards.
  always_comb begin
    wen_sel   = core_wen;
    waddr_sel = core_addr;
    wdata_sel = core_data;
    if (!init_done) begin
      wen_sel   = init_wen;
      waddr_sel = init_addr;
      wdata_sel = init_data;
    end
  end

  // Byte-masked write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BE); b++) begin
      if (wen_sel[b]) begin
        mem[waddr_sel][b*8 +: 8] <= wdata_sel[b*8 +: 8];
      end
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/m_latency_memory.sv
// Word memory with separate configurable read/write latencies and a stall handshake.
// Optional statistics counters are built when MEM_STATS_EN is defined; otherwise the
// statistics ports are tied to zero.
module m_latency_memory
  import m_latency_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned READ_LATENCY  = 4,
  parameter int unsigned WRITE_LATENCY = 2,
  localparam int unsigned BE           = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_x,
  input  logic                  i_init_done,
  input  logic [BE-1:0]         i_init_wen,
  input  logic [ADDR_WIDTH-1:0] i_init_addr,
  input  logic [DATA_WIDTH-1:0] i_init_data,
  input  logic                  i_ren,
  input  logic [BE-1:0]         i_wen,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_stall,
  output logic [31:0]           o_rd_count,
  output logic [31:0]           o_wr_count,
  output logic [31:0]           o_stall_cycles
);

  localparam logic [CntW-1:0] RdCntInit =
      (READ_LATENCY > 0) ? CntW'(READ_LATENCY - 1) : '0;
  localparam logic [CntW-1:0] WrCntInit =
      (WRITE_LATENCY > 0) ? CntW'(WRITE_LATENCY - 1) : '0;
  localparam bit RdZero = (READ_LATENCY == 0);
  localparam bit WrZero = (WRITE_LATENCY == 0);

  lmem_state_e           state_q;
  logic [CntW-1:0]       cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BE-1:0]         be_q;

  logic                  wr_req, rd_req, is_idle, wait_done, stall_raw;
  logic [BE-1:0]         core_wen;
  logic [ADDR_WIDTH-1:0] core_addr;
  logic [DATA_WIDTH-1:0] core_data;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // Write wins over a simultaneous read.
  assign wr_req    = |i_wen;
  assign rd_req    = i_ren & ~wr_req;
  assign is_idle   = (state_q == StIdle);
  assign wait_done = !is_idle && (cnt_q == '0);

  // Stall: any request during preload, a latent request in idle, or an unfinished wait.
  always_comb begin
    stall_raw = 1'b0;
    if (is_idle) begin
      if (!i_init_done) begin
        stall_raw = wr_req | i_ren;
      end else if (wr_req) begin
        stall_raw = !WrZero;
      end else if (i_ren) begin
        stall_raw = !RdZero;
      end
    end else begin
      stall_raw = (cnt_q != '0);
    end
  end

  // Reset forces the stall low at once, even with a request still held.
  assign o_stall = i_rst_x & stall_raw;

  // Core write port: deferred commit from the latched write, or direct zero-latency write.
  always_comb begin
    core_wen  = '0;
    core_addr = i_addr;
    core_data = i_data;
    if (state_q == StWriteWait && wait_done) begin
      core_wen  = be_q;
      core_addr = addr_q;
      core_data = wdata_q;
    end else if (is_idle && i_init_done && WrZero) begin
      core_wen = i_wen;
    end
  end

  // Zero-latency reads look up the live address; otherwise the latched one.
  assign rd_addr = (is_idle && RdZero) ? i_addr : addr_q;

  // Access sequencer: accept in idle, count down, return to idle on completion.
  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_init_done) begin
            if (wr_req && !WrZero) begin
              addr_q  <= i_addr;
              wdata_q <= i_data;
              be_q    <= i_wen;
              cnt_q   <= WrCntInit;
              state_q <= StWriteWait;
            end else if (rd_req && !RdZero) begin
              addr_q  <= i_addr;
              cnt_q   <= RdCntInit;
              state_q <= StReadWait;
            end
          end
        end
        StReadWait, StWriteWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            // The request still held in the completion cycle is consumed here.
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  m_lmem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_array (
    .clk      (i_clk),
    .init_done(i_init_done),
    .init_wen (i_init_wen),
    .init_addr(i_init_addr),
    .init_data(i_init_data),
    .core_wen (core_wen),
    .core_addr(core_addr),
    .core_data(core_data),
    .rd_addr  (rd_addr),
    .rd_data  (o_data)
  );

`ifdef MEM_STATS_EN
  logic rd_done, wr_done;
  logic [31:0] rd_count_q, wr_count_q, stall_cycles_q;

  assign rd_done = (state_q == StReadWait && wait_done) ||
                   (is_idle && i_init_done && rd_req && RdZero);
  assign wr_done = (state_q == StWriteWait && wait_done) ||
                   (is_idle && i_init_done && wr_req && WrZero);

  // Saturating activity counters.
  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      rd_count_q     <= '0;
      wr_count_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (rd_done) rd_count_q <= sat_inc(rd_count_q);
      if (wr_done) wr_count_q <= sat_inc(wr_count_q);
      if (o_stall) stall_cycles_q <= sat_inc(stall_cycles_q);
    end
  end

  assign o_rd_count     = rd_count_q;
  assign o_wr_count     = wr_count_q;
  assign o_stall_cycles = stall_cycles_q;
`else
  assign o_rd_count     = '0;
  assign o_wr_count     = '0;
  assign o_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_m_latency_memory.sv
// Self-checking bench for m_latency_memory: a default-latency instance (4/2) and a
// zero-latency instance sharing the init port, checked against array models.
module tb_m_latency_memory;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
  localparam int RL = 4;
  localparam int WL = 2;

  logic clk, rst_n, init_done;
  logic [3:0]  init_wen;
  logic [AW-1:0] init_addr;
  logic [DW-1:0] init_data;

  logic ren;
  logic [3:0] wen;
  logic [AW-1:0] addr;
  logic [DW-1:0] data, rdata;
  logic stall;
  logic [31:0] rd_cnt, wr_cnt, stall_cyc;

  logic z_ren;
  logic [3:0] z_wen;
  logic [AW-1:0] z_addr;
  logic [DW-1:0] z_data, z_rdata;
  logic z_stall;
  logic [31:0] z_rd_cnt, z_wr_cnt, z_stall_cyc;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] model  [512];
  logic [DW-1:0] zmodel [512];

  m_latency_memory #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .i_clk(clk), .i_rst_x(rst_n), .i_init_done(init_done), .i_init_wen(init_wen),
    .i_init_addr(init_addr), .i_init_data(init_data), .i_ren(ren), .i_wen(wen),
    .i_addr(addr), .i_data(data), .o_data(rdata), .o_stall(stall),
    .o_rd_count(rd_cnt), .o_wr_count(wr_cnt), .o_stall_cycles(stall_cyc)
  );

  m_latency_memory #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(0), .WRITE_LATENCY(0)
  ) dut_zero (
    .i_clk(clk), .i_rst_x(rst_n), .i_init_done(init_done), .i_init_wen(init_wen),
    .i_init_addr(init_addr), .i_init_data(init_data), .i_ren(z_ren), .i_wen(z_wen),
    .i_addr(z_addr), .i_data(z_data), .o_data(z_rdata), .o_stall(z_stall),
    .o_rd_count(z_rd_cnt), .o_wr_count(z_wr_cnt), .o_stall_cycles(z_stall_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // One access on the latent instance: expects exactly latency stall cycles.
  task automatic access(input logic r, input logic [3:0] w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input string nm, output logic [DW-1:0] got);
    int n, exp_stall;
    bit done, is_wr;
    logic [DW-1:0] exp_d;
    is_wr = (w != 4'h0);
    exp_stall = is_wr ? WL : RL;
    exp_d = model[a];
    ren = r; wen = w; addr = a; data = d;
    n = 0; done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (stall) begin
        n++;
        @(posedge clk);
      end else begin
        done = 1;
      end
    end
    got = rdata;
    vectors++;
    if (!done || n != exp_stall) begin
      miscompares++;
      $display("FAIL %s stall_cycles: got %0d (done=%0d) expected %0d", nm, n, done, exp_stall);
    end
    if (!is_wr && r) begin
      vectors++;
      if (got !== exp_d) begin
        miscompares++;
        $display("FAIL %s read_data: got %08h expected %08h", nm, got, exp_d);
      end
    end
    if (is_wr) model[a] = merge(model[a], d, w);
    @(posedge clk); #1;
    ren = 1'b0; wen = 4'h0;
  endtask

  // One single-cycle access on the zero-latency instance.
  task automatic z_op(input logic r, input logic [3:0] w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input string nm);
    z_ren = r; z_wen = w; z_addr = a; z_data = d;
    @(negedge clk);
    vectors++;
    if (z_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL %s zero_stall: got %b expected 0", nm, z_stall);
    end
    if (r && w == 4'h0) begin
      vectors++;
      if (z_rdata !== zmodel[a]) begin
        miscompares++;
        $display("FAIL %s zero_read: got %08h expected %08h", nm, z_rdata, zmodel[a]);
      end
    end
    if (w != 4'h0) zmodel[a] = merge(zmodel[a], d, w);
    @(posedge clk); #1;
    z_ren = 1'b0; z_wen = 4'h0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0 || z_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_stall: got %b/%b expected 0/0", stall, z_stall);
    end
    vectors++;
    if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0 || stall_cyc !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_stats: got %0d/%0d/%0d expected 0/0/0", rd_cnt, wr_cnt, stall_cyc);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle_stall: got %b expected 0", stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_init;
    logic [DW-1:0] v;
    int n;
    bit done;
    for (int i = 0; i < 512; i++) begin
      v = (i == 5) ? 32'hdeadbeef : (i == 7 || i == 3) ? 32'h0 : $urandom;
      init_wen = 4'hf; init_addr = AW'(i); init_data = v;
      model[i] = v; zmodel[i] = v;
      @(posedge clk); #1;
    end
    v = $urandom;
    init_wen = 4'b0011; init_addr = 9'd9; init_data = v;
    model[9] = merge(model[9], v, 4'b0011); zmodel[9] = model[9];
    @(posedge clk); #1;
    init_wen = 4'h0;
    // Read held during preload must stall and only start once preload ends.
    ren = 1'b1; addr = 9'd5;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (stall !== 1'b1) begin
        miscompares++;
        $display("FAIL init_hold_stall: got %b expected 1", stall);
      end
      @(posedge clk);
    end
    #1 init_done = 1'b1;
    n = 0; done = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (stall) begin n++; @(posedge clk); end
      else done = 1;
    end
    vectors++;
    if (!done || n != RL) begin
      miscompares++;
      $display("FAIL init_read_stall: got %0d expected %0d", n, RL);
    end
    vectors++;
    if (rdata !== 32'hdeadbeef) begin
      miscompares++;
      $display("FAIL init_read_data: got %08h expected deadbeef", rdata);
    end
    @(posedge clk); #1;
    ren = 1'b0;
  endtask

  task automatic test_byte_write;
    logic [DW-1:0] got;
    access(1'b0, 4'b0101, 9'd7, 32'h11223344, "byte_write", got);
    access(1'b1, 4'h0, 9'd7, 32'h0, "byte_readback", got);
    vectors++;
    if (got !== 32'h00220044) begin
      miscompares++;
      $display("FAIL byte_merge_value: got %08h expected 00220044", got);
    end
  endtask

  task automatic test_write_wins;
    logic [DW-1:0] got, d;
    d = $urandom;
    access(1'b1, 4'hf, 9'd11, d, "rw_together_as_write", got);
    access(1'b1, 4'h0, 9'd11, 32'h0, "rw_together_readback", got);
  endtask

  task automatic test_random;
    logic [DW-1:0] got;
    logic [AW-1:0] a;
    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        access(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)), a, $urandom, "rand_write", got);
      else
        access(1'b1, 4'h0, a, 32'h0, "rand_read", got);
    end
  endtask

  task automatic test_reset_writewait;
    logic [DW-1:0] old, got;
    old = model[20];
    ren = 1'b0; wen = 4'hf; addr = 9'd20; data = ~old;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL ww_accept_stall: got %b expected 1", stall);
    end
    @(posedge clk); #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("FAIL ww_cnt1_stall: got %b expected 1", stall);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL ww_reset_stall_drop: got %b expected 0", stall);
    end
    wen = 4'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(1'b1, 4'h0, 9'd20, 32'h0, "ww_target_unchanged", got);
  endtask

  task automatic test_alias_stats;
    logic [DW-1:0] got;
    logic [9:0] wide;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wide = 10'h205;
    access(1'b0, 4'hf, wide[AW-1:0], 32'ha5a55a5a, "alias_write", got);
    access(1'b0, 4'b1100, 9'd6, $urandom, "stats_write2", got);
    access(1'b1, 4'h0, 9'd5, 32'h0, "alias_read5", got);
    vectors++;
    if (got !== 32'ha5a55a5a) begin
      miscompares++;
      $display("FAIL alias_value: got %08h expected a5a55a5a", got);
    end
    access(1'b1, 4'h0, 9'd6, 32'h0, "stats_read6", got);
    access(1'b1, 4'h0, wide[AW-1:0], 32'h0, "alias_read_wide", got);
    @(negedge clk);
`ifdef MEM_STATS_EN
    vectors++;
    if (rd_cnt !== 32'd3 || wr_cnt !== 32'd2 || stall_cyc !== 32'd16) begin
      miscompares++;
      $display("FAIL stats_counts: got %0d/%0d/%0d expected 3/2/16", rd_cnt, wr_cnt, stall_cyc);
    end
`else
    vectors++;
    if (rd_cnt !== 32'd0 || wr_cnt !== 32'd0 || stall_cyc !== 32'd0) begin
      miscompares++;
      $display("FAIL stats_tied_zero: got %0d/%0d/%0d expected 0/0/0", rd_cnt, wr_cnt, stall_cyc);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_zero_latency;
    z_op(1'b1, 4'h0, 9'd3, 32'h0, "zero_read1");
    z_op(1'b0, 4'hf, 9'd3, 32'hcafef00d, "zero_write");
    z_op(1'b1, 4'h0, 9'd3, 32'h0, "zero_read2");
    vectors++;
    if (zmodel[3] !== 32'hcafef00d || z_rdata !== 32'hcafef00d) begin
      miscompares++;
      $display("FAIL zero_back_to_back: got %08h expected cafef00d", z_rdata);
    end
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1)
        z_op(1'b0, 4'($urandom_range(1, 15)), AW'($urandom_range(0, 7)), $urandom, "zero_rand_w");
      else
        z_op(1'b1, 4'h0, AW'($urandom_range(0, 7)), 32'h0, "zero_rand_r");
    end
  endtask

  initial begin
    rst_n = 1'b0; init_done = 1'b0;
    init_wen = '0; init_addr = '0; init_data = '0;
    ren = 1'b0; wen = '0; addr = '0; data = '0;
    z_ren = 1'b0; z_wen = '0; z_addr = '0; z_data = '0;
    test_reset();
    test_init();
    test_byte_write();
    test_write_wins();
    test_random();
    test_reset_writewait();
    test_alias_stats();
    test_zero_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
